// File: rtl/unary_mac_pkg.sv
// Shared types and helpers for the unary shift MAC datapath.
package unary_mac_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } piso_state_t;

   function automatic int cnt_w(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry holding register: load captures a word, drain empties it; load wins when both occur.
// Latency 1 cycle load-to-full; the owner gates load with !full_o, so the buffer never applies backpressure itself.
module piso_hold_buf #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load_i,
   input  logic [W-1:0] load_dat_i,
   input  logic         drain_i,
   output logic         full_o,
   output logic [W-1:0] dat_o
);

   logic         full_q, full_d;
   logic [W-1:0] dat_q, dat_d;

   always_comb begin
      full_d = full_q;
      dat_d  = dat_q;
      if (drain_i) begin
         full_d = 1'b0;
      end
      if (load_i) begin
         full_d = 1'b1;
         dat_d  = load_dat_i;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         full_q <= 1'b0;
         dat_q  <= '0;
      end else begin
         full_q <= full_d;
         dat_q  <= dat_d;
      end
   end

   assign full_o = full_q;
   assign dat_o  = dat_q;

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: one bit per consumer shift strobe, one-word holding buffer for gapless streaming.
// First bit 1 cycle after accept; in_ready drops only while the holding buffer is full.
module piso_shift_tx
   import unary_mac_pkg::*;
#(
   parameter int N     = 16,
   parameter bit RIGHT = 1'b1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [N-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         shift,
   output logic         out_bit,
   output logic         out_valid,
   output logic         out_last,
   output logic         busy
);

   localparam int CW = cnt_w(N);

   piso_state_t   state_q, state_d;
   logic [N-1:0]  sh_q, sh_d, sh_shifted;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  hold_q;
   logic          hold_full, hold_load, hold_drain;
   logic          accept, consume, last_consume;

   piso_hold_buf #(.W(N)) u_hold (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_i     (hold_load),
      .load_dat_i (in_data),
      .drain_i    (hold_drain),
      .full_o     (hold_full),
      .dat_o      (hold_q)
   );

   assign in_ready     = !hold_full;
   assign accept       = in_valid && in_ready;
   assign consume      = shift && out_valid;
   assign last_consume = consume && out_last;
   assign sh_shifted   = RIGHT ? (sh_q >> 1) : (sh_q << 1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         sh_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = SHIFT;
         SHIFT:   if (last_consume && !hold_full && !in_valid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // At the last bit the held word takes priority, then a word offered this cycle.
   always_comb begin
      sh_d       = sh_q;
      cnt_d      = cnt_q;
      hold_load  = 1'b0;
      hold_drain = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               sh_d  = in_data;
               cnt_d = '0;
            end
         end
         SHIFT: begin
            if (last_consume) begin
               cnt_d = '0;
               if (hold_full) begin
                  sh_d       = hold_q;
                  hold_drain = 1'b1;
                  hold_load  = accept;
               end else if (in_valid) begin
                  sh_d = in_data;
               end else begin
                  sh_d = '0;
               end
            end else begin
               if (consume) begin
                  sh_d  = sh_shifted;
                  cnt_d = cnt_q + 1'b1;
               end
               hold_load = accept;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      out_valid = (state_q == SHIFT);
      out_bit   = 1'b0;
      if (out_valid) begin
         out_bit = RIGHT ? sh_q[0] : sh_q[N-1];
      end
      out_last = out_valid && (cnt_q == CW'(N-1));
      busy     = out_valid || hold_full;
   end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed vectors on N=8 LSB-first and MSB-first instances, plus an N=16 loopback against a receiver model.
module tb_piso_shift_tx;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  d8 = '0;
   logic        iv8 = 1'b0, sh8 = 1'b0;
   logic [15:0] d16 = '0;
   logic        iv16 = 1'b0, sh16 = 1'b0;

   logic a_rdy, a_bit, a_vld, a_last, a_busy;
   logic b_rdy, b_bit, b_vld, b_last, b_busy;
   logic c_rdy, c_bit, c_vld, c_last, c_busy;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   piso_shift_tx #(.N(8), .RIGHT(1'b1)) u_a (
      .clk(clk), .reset_n(reset_n), .in_data(d8), .in_valid(iv8), .in_ready(a_rdy),
      .shift(sh8), .out_bit(a_bit), .out_valid(a_vld), .out_last(a_last), .busy(a_busy)
   );

   piso_shift_tx #(.N(8), .RIGHT(1'b0)) u_b (
      .clk(clk), .reset_n(reset_n), .in_data(d8), .in_valid(iv8), .in_ready(b_rdy),
      .shift(sh8), .out_bit(b_bit), .out_valid(b_vld), .out_last(b_last), .busy(b_busy)
   );

   piso_shift_tx #(.N(16), .RIGHT(1'b1)) u_c (
      .clk(clk), .reset_n(reset_n), .in_data(d16), .in_valid(iv16), .in_ready(c_rdy),
      .shift(sh16), .out_bit(c_bit), .out_valid(c_vld), .out_last(c_last), .busy(c_busy)
   );

   // Observed N=8 outputs: {a_bit,b_bit,a_vld,b_vld,a_last,b_last,a_rdy,b_rdy,a_busy,b_busy}
   logic [9:0] obs;
   assign obs = {a_bit, b_bit, a_vld, b_vld, a_last, b_last, a_rdy, b_rdy, a_busy, b_busy};

   typedef struct {
      logic       iv;
      logic [7:0] d;
      logic       sh;
      logic       er;
      logic       el;
      logic       ev;
      logic       elast;
      logic       erdy;
      logic       ebusy;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic iv, input logic [7:0] d, input logic sh,
                      input logic er, input logic el, input logic ev,
                      input logic elast, input logic erdy, input logic ebusy);
      vec_t v;
      v.iv = iv; v.d = d; v.sh = sh;
      v.er = er; v.el = el; v.ev = ev; v.elast = elast; v.erdy = erdy; v.ebusy = ebusy;
      vecs.push_back(v);
   endtask

   function automatic logic [9:0] pack(input logic er, input logic el, input logic ev,
                                       input logic elast, input logic erdy, input logic ebusy);
      return {er, el, ev, ev, elast, elast, erdy, erdy, ebusy, ebusy};
   endfunction

   // Expected N=8 outputs while word w sits at bit index k.
   function automatic logic [9:0] expw(input logic [7:0] w, input int k,
                                       input logic erdy, input logic ebusy);
      return pack(w[k], w[7-k], 1'b1, k == 7, erdy, ebusy);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [9:0]  idle_obs;
   logic [15:0] rx, rx_n, pw;
   logic [15:0] expq[$];
   logic        pend, acc, cons, lastc;
   int          done, gen, cyc;

   initial begin
      idle_obs = pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Single word 0xA5: LSB-first and MSB-first both read 1,0,1,0,0,1,0,1.
      add(1, 8'hA5, 0, 1, 1, 1, 0, 1, 1);
      add(0, 8'h00, 1, 0, 0, 1, 0, 1, 1);
      add(0, 8'h00, 1, 1, 1, 1, 0, 1, 1);
      add(0, 8'h00, 1, 0, 0, 1, 0, 1, 1);
      add(0, 8'h00, 1, 0, 0, 1, 0, 1, 1);
      add(0, 8'h00, 1, 1, 1, 1, 0, 1, 1);
      add(0, 8'h00, 1, 0, 0, 1, 0, 1, 1);
      add(0, 8'h00, 1, 1, 1, 1, 1, 1, 1);
      add(0, 8'h00, 1, 0, 0, 0, 0, 1, 0);
      add(0, 8'h00, 1, 0, 0, 0, 0, 1, 0);
      // 0x0F then 0xF0 back-to-back through the holding buffer; 0x77 offered while full is refused.
      add(1, 8'h0F, 0, 1, 0, 1, 0, 1, 1);
      add(1, 8'hF0, 1, 1, 0, 1, 0, 0, 1);
      add(1, 8'h77, 1, 1, 0, 1, 0, 0, 1);
      add(0, 8'h00, 1, 1, 0, 1, 0, 0, 1);
      add(0, 8'h00, 1, 0, 1, 1, 0, 0, 1);
      add(0, 8'h00, 1, 0, 1, 1, 0, 0, 1);
      add(0, 8'h00, 1, 0, 1, 1, 0, 0, 1);
      add(0, 8'h00, 1, 0, 1, 1, 1, 0, 1);
      add(0, 8'h00, 1, 0, 1, 1, 0, 1, 1);
      add(0, 8'h00, 1, 0, 1, 1, 0, 1, 1);
      add(0, 8'h00, 1, 0, 1, 1, 0, 1, 1);
      add(0, 8'h00, 1, 0, 1, 1, 0, 1, 1);
      add(0, 8'h00, 1, 1, 0, 1, 0, 1, 1);
      add(0, 8'h00, 1, 1, 0, 1, 0, 1, 1);
      add(0, 8'h00, 1, 1, 0, 1, 0, 1, 1);
      add(0, 8'h00, 1, 1, 0, 1, 1, 1, 1);
      add(0, 8'h00, 1, 0, 0, 0, 0, 1, 0);
      // 0x80, then 0x01 offered exactly at the last bit loads straight into the shifter.
      add(1, 8'h80, 1, 0, 1, 1, 0, 1, 1);
      for (int k = 1; k < 7; k++) add(0, 8'h00, 1, 0, 0, 1, 0, 1, 1);
      add(0, 8'h00, 1, 1, 0, 1, 1, 1, 1);
      add(1, 8'h01, 1, 1, 0, 1, 0, 1, 1);
      add(0, 8'h00, 0, 1, 0, 1, 0, 1, 1);
      for (int k = 1; k < 7; k++) add(0, 8'h00, 1, 0, 0, 1, 0, 1, 1);
      add(0, 8'h00, 1, 0, 1, 1, 1, 1, 1);
      add(0, 8'h00, 1, 0, 0, 0, 0, 1, 0);

      // Reset values while reset is held.
      #2;
      chk("reset_n8", {22'd0, obs}, {22'd0, idle_obs});
      chk("reset_n16", {28'd0, c_bit, c_vld, c_last, c_rdy}, 32'b0001);
      chk("reset_busy16", {31'd0, c_busy}, 32'd0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      chk("post_reset", {22'd0, obs}, {22'd0, idle_obs});

      for (int i = 0; i < vecs.size(); i++) begin
         iv8 = vecs[i].iv;
         d8  = vecs[i].d;
         sh8 = vecs[i].sh;
         tick();
         chk($sformatf("vec%0d", i), {22'd0, obs},
             {22'd0, pack(vecs[i].er, vecs[i].el, vecs[i].ev, vecs[i].elast,
                          vecs[i].erdy, vecs[i].ebusy)});
      end

      // Stall: 0x3C frozen at bit 3 for 5 cycles, then resumes.
      iv8 = 1; d8 = 8'h3C; sh8 = 0;
      tick();
      iv8 = 0;
      chk("stall_b0", {22'd0, obs}, {22'd0, expw(8'h3C, 0, 1'b1, 1'b1)});
      sh8 = 1;
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk($sformatf("stall_b%0d", k), {22'd0, obs}, {22'd0, expw(8'h3C, k, 1'b1, 1'b1)});
      end
      sh8 = 0;
      for (int s = 0; s < 5; s++) begin
         tick();
         chk($sformatf("stall_hold%0d", s), {22'd0, obs}, {22'd0, expw(8'h3C, 3, 1'b1, 1'b1)});
      end
      sh8 = 1;
      for (int k = 4; k <= 7; k++) begin
         tick();
         chk($sformatf("stall_b%0d", k), {22'd0, obs}, {22'd0, expw(8'h3C, k, 1'b1, 1'b1)});
      end
      tick();
      chk("stall_idle", {22'd0, obs}, {22'd0, idle_obs});

      // Reset at bit 4 with 0x55 held; both words must vanish.
      iv8 = 1; d8 = 8'hFF; sh8 = 0;
      tick();
      d8 = 8'h55; sh8 = 1;
      tick();
      iv8 = 0;
      tick();
      tick();
      tick();
      chk("rst_pre_b4", {22'd0, obs}, {22'd0, expw(8'hFF, 4, 1'b0, 1'b1)});
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_async", {22'd0, obs}, {22'd0, idle_obs});
      tick();
      reset_n = 1'b1;
      tick();
      chk("rst_after", {22'd0, obs}, {22'd0, idle_obs});
      iv8 = 1; d8 = 8'h01; sh8 = 0;
      tick();
      iv8 = 0; sh8 = 1;
      chk("rst_w01_b0", {22'd0, obs}, {22'd0, expw(8'h01, 0, 1'b1, 1'b1)});
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk($sformatf("rst_w01_b%0d", k), {22'd0, obs}, {22'd0, expw(8'h01, k, 1'b1, 1'b1)});
      end
      tick();
      chk("rst_w01_idle", {22'd0, obs}, {22'd0, idle_obs});
      sh8 = 0;

      // N=16 loopback into an LSB-first receiver model with random duty on both sides.
      rx = '0; pend = 0; pw = '0; done = 0; gen = 0; cyc = 0;
      while (done < 200 && cyc < 20000) begin
         if (!pend && gen < 200 && $urandom_range(0, 99) < 60) begin
            pw   = 16'($urandom);
            pend = 1;
            gen++;
         end
         iv16  = pend;
         d16   = pw;
         sh16  = ($urandom_range(0, 99) < 70);
         acc   = iv16 && c_rdy;
         cons  = sh16 && c_vld;
         lastc = cons && c_last;
         if (acc) expq.push_back(pw);
         rx_n  = {c_bit, rx[15:1]};
         tick();
         cyc++;
         if (acc) pend = 0;
         if (cons) rx = rx_n;
         if (lastc) begin
            if (expq.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL loop_extra_word: got word %h expected none", rx);
            end else begin
               chk($sformatf("loop%0d", done), {16'd0, rx}, {16'd0, expq.pop_front()});
            end
            done++;
         end
      end
      iv16 = 0; sh16 = 0;
      chk("loop_words", done, 200);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
